// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 single-wire bitstream receiver producing {R,G,B} words with LED index.
// Ports: clk, reset (sync, active-high), data_in (async line), rgb_data[23:0], led_num[7:0],
//        valid / frame_done / err (one-cycle strobes).
module ws2812_rx #(
  parameter int HIGH_THRESH  = 6,
  parameter int MAX_HIGH     = 20,
  parameter int RESET_CYCLES = 600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_in,
  output logic [23:0] rgb_data,
  output logic [7:0]  led_num,
  output logic        valid,
  output logic        frame_done,
  output logic        err
);
  localparam int LW = $clog2(RESET_CYCLES);
  localparam logic [LW-1:0] GAP_TC = LW'(RESET_CYCLES - 1);
  localparam logic [7:0] THR = 8'(HIGH_THRESH);
  localparam logic [7:0] MAXH = 8'(MAX_HIGH);
  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;
  state_t state;
  logic s1, d_s, d_q, rise, fall;
  logic [7:0] hcnt, leds;
  logic [LW-1:0] lcnt;
  logic [4:0] bits;
  logic [23:0] sr, word;
  assign rise = d_s & ~d_q;
  assign fall = ~d_s & d_q;
  // word as it stands once the bit now being closed is shifted in
  assign word = {sr[22:0], hcnt >= THR};
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      d_s <= 1'b0;
      d_q <= 1'b0;
      state <= SYNC;
      hcnt <= '0;
      lcnt <= '0;
      leds <= '0;
      bits <= '0;
      sr <= '0;
      rgb_data <= '0;
      led_num <= '0;
      valid <= 1'b0;
      frame_done <= 1'b0;
      err <= 1'b0;
    end else begin
      s1 <= data_in;
      d_s <= s1;
      d_q <= d_s;
      valid <= 1'b0;
      frame_done <= 1'b0;
      err <= 1'b0;
      case (state)
        SYNC: begin
          // wait for a full gap so we never lock onto the middle of a frame
          lcnt <= d_s ? '0 : lcnt + LW'(1);
          if (!d_s && lcnt == GAP_TC) begin
            state <= IDLE;
            lcnt <= '0;
            bits <= '0;
            leds <= '0;
          end
        end
        IDLE: if (rise) begin
          state <= HIGH;
          hcnt <= 8'd1;
        end
        HIGH: begin
          // an over-long pulse is an error even if it ends in this very cycle
          if (hcnt > MAXH) begin
            err <= 1'b1;
            state <= SYNC;
            lcnt <= '0;
          end else if (fall) begin
            state <= LOW;
            lcnt <= LW'(1);
            if (bits == 5'd23) begin
              rgb_data <= {word[15:8], word[23:16], word[7:0]};
              led_num <= leds;
              valid <= 1'b1;
              leds <= leds + 8'd1;
              bits <= '0;
            end else begin
              sr <= word;
              bits <= bits + 5'd1;
            end
          end else begin
            hcnt <= hcnt + {7'd0, hcnt != 8'hff};
          end
        end
        LOW: begin
          if (rise) begin
            state <= HIGH;
            hcnt <= 8'd1;
          end else if (lcnt == GAP_TC) begin
            state <= IDLE;
            frame_done <= 1'b1;
            err <= bits != 5'd0;
            bits <= '0;
            leds <= '0;
          end else begin
            lcnt <= lcnt + LW'(1);
          end
        end
        default: state <= SYNC;
      endcase
    end
  end
endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: directed stimulus for ws2812_rx, checked every cycle against a run-length line model.
module tb_ws2812_rx;
  localparam int THR = 6;
  localparam int MAXH = 20;
  localparam int GAP = 600;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic data_in = 1'b0;
  logic [23:0] rgb_data;
  logic [7:0] led_num;
  logic valid, frame_done, err;
  ws2812_rx dut (
    .clk(clk),
    .reset(reset),
    .data_in(data_in),
    .rgb_data(rgb_data),
    .led_num(led_num),
    .valid(valid),
    .frame_done(frame_done),
    .err(err)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic v;
    logic fd;
    logic er;
    logic [23:0] rgb;
    logic [7:0] led;
  } ev_t;
  ev_t p0, p1, cur;
  logic [23:0] exp_rgb, acc;
  logic [7:0] exp_led;
  bit armed, hunting, in_frame;
  int cyc, checks, passes, fall_edge;
  int sync_low, high_run, low_run, nbits, leds;
  int n_fd, n_err, n_both;
  logic [23:0] rgb_log[$];
  int led_log[$];
  int vedge_log[$];
  // Line model: pulses are measured as runs of pin samples; each decision
  // taken on a sample shows up on the outputs three edges later.
  task automatic model_reset();
    p0 = '0;
    p1 = '0;
    cur = '0;
    exp_rgb = '0;
    exp_led = '0;
    armed = 1;
    hunting = 1;
    sync_low = 2;
    in_frame = 0;
    high_run = 0;
    low_run = 0;
    nbits = 0;
    leds = 0;
    acc = '0;
  endtask
  task automatic model_step(input logic p);
    ev_t e;
    e = '0;
    if (hunting) begin
      sync_low = p ? 0 : sync_low + 1;
      if (sync_low == GAP) begin
        hunting = 0;
        in_frame = 0;
        nbits = 0;
        leds = 0;
      end
    end else if (high_run > MAXH) begin
      e.er = 1'b1;
      hunting = 1;
      high_run = 0;
      sync_low = p ? 0 : 1;
    end else if (high_run > 0 && p) begin
      high_run++;
    end else if (high_run > 0) begin
      acc = {acc[22:0], high_run >= THR};
      nbits++;
      high_run = 0;
      in_frame = 1;
      low_run = 1;
      if (nbits == 24) begin
        e.v = 1'b1;
        e.rgb = {acc[15:8], acc[23:16], acc[7:0]};
        e.led = 8'(leds);
        leds = (leds + 1) % 256;
        nbits = 0;
      end
    end else if (p) begin
      high_run = 1;
    end else if (in_frame) begin
      low_run++;
      if (low_run == GAP) begin
        e.fd = 1'b1;
        e.er = nbits != 0;
        nbits = 0;
        leds = 0;
        in_frame = 0;
      end
    end
    cur = p1;
    p1 = p0;
    p0 = e;
    if (cur.v) begin
      exp_rgb = cur.rgb;
      exp_led = cur.led;
    end
  endtask
  task automatic compare();
    if (!armed) return;
    checks++;
    if ({valid, frame_done, err, rgb_data, led_num} === {cur.v, cur.fd, cur.er, exp_rgb, exp_led})
      passes++;
    else
      $display("FAIL cyc%0d outputs: got v=%b fd=%b err=%b rgb=%h led=%0d want v=%b fd=%b err=%b rgb=%h led=%0d",
               cyc, valid, frame_done, err, rgb_data, led_num, cur.v, cur.fd, cur.er, exp_rgb, exp_led);
    if (valid === 1'b1) begin
      rgb_log.push_back(rgb_data);
      led_log.push_back(int'(led_num));
      vedge_log.push_back(cyc + 1);
    end
    if (frame_done === 1'b1) n_fd++;
    if (err === 1'b1) n_err++;
    if (frame_done === 1'b1 && err === 1'b1) n_both++;
  endtask
  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got == want) passes++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask
  function automatic int rl(input int i);
    return i < rgb_log.size() ? int'(rgb_log[i]) : -1;
  endfunction
  function automatic int ll(input int i);
    return i < led_log.size() ? led_log[i] : -1;
  endfunction
  task automatic put(input logic v, input int n);
    data_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse(input int h, input int l);
    put(1'b1, h);
    fall_edge = cyc + 1;
    put(1'b0, l);
  endtask
  task automatic send_bits(input logic [23:0] w, input int n, input bit fast);
    for (int i = n - 1; i >= 0; i--)
      if (fast) pulse(w[i] ? 6 : 4, w[i] ? 4 : 6);
      else pulse(w[i] ? 8 : 4, w[i] ? 7 : 11);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask
  initial begin
    int base, lf;
    logic [23:0] w;
    fork
      forever begin
        @(posedge clk);
        cyc++;
        if (reset) model_reset();
        else model_step(data_in);
      end
      forever begin
        @(negedge clk);
        compare();
      end
    join_none
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_rgb", int'(rgb_data), 0);
    chk("reset_led", int'(led_num), 0);
    chk("reset_strobes", int'({valid, frame_done, err}), 0);
    // single word after a clean gap
    put(1'b0, 650);
    send_bits(24'h00FF00, 24, 0);
    put(1'b0, 650);
    chk("t1_nvalid", rgb_log.size(), 1);
    chk("t1_rgb", rl(0), 24'hFF0000);
    chk("t1_led", ll(0), 0);
    chk("t1_fd", n_fd, 1);
    chk("t1_err", n_err, 0);
    // three words back to back
    send_bits(24'h341256, 24, 0);
    send_bits(24'hCDABEF, 24, 0);
    send_bits(24'h000001, 24, 0);
    lf = fall_edge;
    put(1'b0, 650);
    chk("t2_rgb0", rl(1), 24'h123456);
    chk("t2_rgb1", rl(2), 24'hABCDEF);
    chk("t2_rgb2", rl(3), 24'h000001);
    chk("t2_led0", ll(1), 0);
    chk("t2_led1", ll(2), 1);
    chk("t2_led2", ll(3), 2);
    chk("t2_latency", vedge_log.size() == 4 ? vedge_log[3] - lf : -1, 3);
    // widths 20, 5, 6 close the word: bits 1, 0, 1
    for (int i = 0; i < 21; i++) pulse(4, 11);
    pulse(20, 5);
    pulse(5, 10);
    pulse(6, 9);
    put(1'b0, 650);
    chk("t3_thresh_rgb", rl(4), 24'h000005);
    chk("t3_fd", n_fd, 3);
    // over-long pulse, then a word that must be ignored until a full gap
    pulse(21, 10);
    send_bits(24'hFFFFFF, 24, 0);
    put(1'b0, 650);
    chk("t3_err", n_err, 1);
    chk("t3_ignored", rgb_log.size(), 5);
    chk("t3_no_fd", n_fd, 3);
    // partial word at a gap
    send_bits(24'h3FF, 10, 0);
    put(1'b0, 650);
    chk("t4_fd_err_same", n_both, 1);
    chk("t4_no_valid", rgb_log.size(), 5);
    send_bits(24'hFFC0EE, 24, 0);
    put(1'b0, 650);
    chk("t4_rgb", rl(5), 24'hC0FFEE);
    chk("t4_led", ll(5), 0);
    // pulses straight after reset, before any gap
    do_reset();
    send_bits(24'h221133, 24, 0);
    put(1'b0, 650);
    chk("t5_no_valid", rgb_log.size(), 6);
    send_bits(24'h554466, 24, 0);
    put(1'b0, 650);
    chk("t5_rgb", rl(6), 24'h445566);
    chk("t5_led", ll(6), 0);
    // 257 words in one frame at the minimum bit period
    base = rgb_log.size();
    for (int k = 0; k < 257; k++) begin
      w = {k[7:0], ~k[7:0], 8'h5A};
      send_bits(w, 24, 1);
    end
    chk("t6_nvalid", rgb_log.size() - base, 257);
    chk("t6_led255", ll(base + 255), 255);
    chk("t6_rgb255", rl(base + 255), 24'h00FF5A);
    chk("t6_led_wrap", ll(base + 256), 0);
    chk("t6_rgb_wrap", rl(base + 256), 24'hFF005A);
    // reset in the middle of a word
    send_bits(24'hFFF, 12, 1);
    do_reset();
    chk("t6_rst_rgb", int'(rgb_data), 0);
    chk("t6_rst_led", int'(led_num), 0);
    chk("t6_rst_strobes", int'({valid, frame_done, err}), 0);
    base = rgb_log.size();
    send_bits(24'hFFF, 12, 1);
    send_bits(24'h123456, 24, 1);
    put(1'b0, 650);
    chk("t6_rst_ignored", rgb_log.size(), base);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/ws2812_rx.md
# ws2812_rx

WS2812 single-wire bitstream receiver: samples the serial LED data line on a 12 MHz clock, classifies each high pulse as a 0 or 1 by its width, and assembles 24-bit colour words with the index of the LED they address. It is the receiving end of the `ws2812` driver's line protocol. It serves as an on-chip loopback checker for the driver and as the input stage for projects that daisy-chain behind an external WS2812 controller.

## Interface
- `HIGH_THRESH`, 6: high-pulse width in clk cycles at or above which a bit decodes as 1; below decodes as 0.
- `MAX_HIGH`, 20: high-pulse width in clk cycles above which the pulse is a protocol error.
- `RESET_CYCLES`, 600: continuous low time in clk cycles that counts as a latch/reset gap (50 µs at 12 MHz).
- `clk` in 1: 12 MHz system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `data_in` in 1: asynchronous WS2812 data line.
- `rgb_data` out 24: last completed word, `{R,G,B}`.
- `led_num` out 8: index within the frame of the LED whose word is on `rgb_data`.
- `valid` out 1: one-cycle strobe; `rgb_data`/`led_num` newly updated.
- `frame_done` out 1: one-cycle strobe on latch gap after at least one bit received.
- `err` out 1: one-cycle strobe on protocol error.

## Operation
- `data_in` passes through a 2-flop synchroniser. `d_q` is the previous synchronised value. Rise = `d_s & ~d_q`; fall = `~d_s & d_q`.
- State machine:
  - SYNC: entered on reset. Counts consecutive low cycles; a high clears the count. At `RESET_CYCLES` → IDLE. Prevents mid-frame alignment after reset. No strobes are issued in SYNC.
  - IDLE: bit count = 0 and LED count = 0. On rise → HIGH with the high counter at 1.
  - HIGH: the high counter increments each cycle and saturates at 255.
    - On fall: shift in bit (`cnt >= HIGH_THRESH`), then → LOW.
    - If `cnt > MAX_HIGH`: pulse `err`, then → SYNC.
  - LOW: the low counter increments and saturates.
    - On rise → HIGH, with the high counter at 1.
    - At `RESET_CYCLES` → IDLE and pulse `frame_done`.
- Bit assembly:
  - Bits are shifted into a 24-bit register MSB first, in wire order G[7:0], R[7:0], B[7:0].
  - The word is remapped to `{R,G,B}` on output.
- Word completion: on the 24th bit, register `rgb_data`, set `led_num` to the current LED count, and pulse `valid`. Then increment the LED count (wraps 255→0) and clear the bit count.
- Partial word at latch gap (bit count ≠ 0): discard the bits, pulse `err` in the same cycle as `frame_done`, and go to IDLE.
- Reset values:
  - Outputs: `rgb_data` = 0, `led_num` = 0, `valid`/`frame_done`/`err` = 0.
  - Internal: state SYNC, all counters 0.
- `rgb_data` and `led_num` hold their values between `valid` strobes, including across frames.

## Timing
- Synchroniser latency is 2 cycles. A fall is detected in the cycle where `d_s` first reads 0.
- `valid` is registered. It is high in exactly one cycle: the 3rd rising clk edge after the first edge that samples `data_in` low at the end of the 24th high pulse.
- `frame_done` is high for one cycle, `RESET_CYCLES` cycles after fall detection.
- Pulse width is measured on the synchronised signal. A width of N cycles at the pin gives `cnt` = N, ±0 for a clean edge.
- Minimum supported bit period is `HIGH_THRESH` + 4 cycles. Back-to-back words have no dead time; the first bit of word k+1 may start the cycle after `valid`.
- A rise and a gap terminal count in the same cycle: the rise wins, the frame continues and no `frame_done` is issued.
- `reset` mid-frame: outputs clear on the next edge and state → SYNC. The remainder of the current frame is ignored until a full gap is seen.

## Test plan
- After reset, `data_in` held low for 600 cycles, then one word 0x00FF00 sent on the wire (G=0x00, R=0xFF, B=0x00) with 0 = 4H/11L and 1 = 8H/7L → one `valid`, `rgb_data` = 0xFF0000, `led_num` = 0; after a 600-cycle low, one `frame_done`, `err` = 0.
- Three words 0x123456, 0xABCDEF, 0x000001 sent back-to-back (wire order G,R,B) → three `valid` strobes, `led_num` 0, 1, 2, correct `{R,G,B}` each; `valid` exactly 3 edges after the final fall.
- Threshold edges: high widths 5 then 6 cycles → bits 0 then 1. High width 21 → `err`, state SYNC; bits then ignored until 600 low cycles.
- 10 bits followed by a 600-cycle gap → `frame_done` and `err` in the same cycle, no `valid`; the next 24 bits produce `led_num` = 0.
- Pulses started with no prior gap after reset → no `valid` until a 600-cycle low is seen.
- 257 words in one frame → `led_num` sequence wraps 255 → 0. `reset` asserted mid-word → all outputs 0 next cycle and the remaining bits ignored.
